// File: rtl/pc_npc_sequencer_if.sv
// Front-end next-PC bus: ID-stage control and targets in, PC/nPC state out.
interface pc_npc_sequencer_if;
  logic        le;
  logic [1:0]  pc_handler_out_selector;
  logic [31:0] ta;
  logic [31:0] alu_out;
  logic        annul;
  logic [31:0] pc;
  logic [31:0] npc;
  logic        if_id_flush;
  logic        redirect_pending;

  modport master (
    output le, pc_handler_out_selector, ta, alu_out, annul,
    input  pc, npc, if_id_flush, redirect_pending
  );

  modport slave (
    input  le, pc_handler_out_selector, ta, alu_out, annul,
    output pc, npc, if_id_flush, redirect_pending
  );
endinterface

// File: rtl/pc_npc_sequencer.sv
// SPARC front-end PC/nPC pair with delayed-branch semantics. Redirects that
// arrive during a stall are held and replayed once when the stall lifts.
module pc_npc_sequencer #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [31:0] INSTR_BYTES = 32'd4
) (
  input  logic                clk,
  input  logic                reset,
  pc_npc_sequencer_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_STALL   = 2'd1,
    ST_PENDING = 2'd2
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_npc;
  logic        r_flush;
  logic        r_pending;
  logic [31:0] r_hold_tgt;
  logic        r_hold_annul;

  logic        w_is_redirect;
  logic [31:0] w_redirect_tgt;
  logic [31:0] w_sel_next;

  // Selector bit 0 marks a redirect (01 jmpl, 11 call/branch); 10 falls
  // through as sequential. Bit 1 then chooses ta over alu_out.
  always_comb begin
    w_is_redirect  = bus.pc_handler_out_selector[0];
    w_redirect_tgt = bus.pc_handler_out_selector[1] ? bus.ta : bus.alu_out;
    w_sel_next     = w_is_redirect ? w_redirect_tgt : (r_npc + INSTR_BYTES);
  end

  // Sequencer FSM: advances PC/nPC, captures stalled redirects, times the flush.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_RUN;
      r_pc         <= RESET_PC;
      r_npc        <= RESET_PC + INSTR_BYTES;
      r_flush      <= 1'b0;
      r_pending    <= 1'b0;
      r_hold_tgt   <= 32'h0;
      r_hold_annul <= 1'b0;
    end else begin
      case (r_state)
        ST_RUN, ST_STALL: begin
          if (bus.le) begin
            r_pc    <= r_npc;
            r_npc   <= w_sel_next;
            r_flush <= w_is_redirect & bus.annul;
            r_state <= ST_RUN;
          end else begin
            r_flush <= 1'b0;
            if (w_is_redirect) begin
              r_hold_tgt   <= w_redirect_tgt;
              r_hold_annul <= bus.annul;
              r_pending    <= 1'b1;
              r_state      <= ST_PENDING;
            end else begin
              r_state <= ST_STALL;
            end
          end
        end
        ST_PENDING: begin
          // The first captured redirect wins; live selector inputs are ignored.
          if (bus.le) begin
            r_pc      <= r_npc;
            r_npc     <= r_hold_tgt;
            r_flush   <= r_hold_annul;
            r_pending <= 1'b0;
            r_state   <= ST_RUN;
          end else begin
            r_flush <= 1'b0;
          end
        end
        default: begin
          r_flush   <= 1'b0;
          r_pending <= 1'b0;
          r_state   <= ST_RUN;
        end
      endcase
    end
  end

  assign bus.pc               = r_pc;
  assign bus.npc              = r_npc;
  assign bus.if_id_flush      = r_flush;
  assign bus.redirect_pending = r_pending;

endmodule

// File: doc/pc_npc_sequencer.md
Name: pc_npc_sequencer

Overview:
- Owns the architectural PC/nPC register pair of the SPARC pipeline front end.
- Consumes the 2-bit next-PC selector from the ID-stage next-PC control logic, plus the branch/call target and the ALU (jmpl) target, and advances PC/nPC with delayed-branch semantics.
- Captures redirects that arrive while the front end is stalled and replays them once on release.
- Generates the one-cycle IF/ID flush pulse used to annul a delay-slot instruction.

Parameters:
- RESET_PC, 32'h0000_0000, PC value after reset.
- INSTR_BYTES, 4, sequential increment added to nPC.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- le  in  1  load enable; 0 = front-end stall, PC/nPC hold.
- pc_handler_out_selector  in  2  next-PC select: 00 sequential (nPC+4); 01 ALU target (jmpl); 10 reserved, treated as 00; 11 target address (call/taken branch).
- ta  in  32  call/branch target address from ID.
- alu_out  in  32  jmpl target from the ALU.
- annul  in  1  ID-stage request to annul the delay-slot instruction; meaningful only with a redirect (selector 01/11).
- pc  out  32  current fetch address.
- npc  out  32  next fetch address.
- if_id_flush  out  1  one-cycle pulse that squashes the instruction in IF/ID.
- redirect_pending  out  1  high while a captured redirect awaits replay.

Behaviour:
- Reset (reset=1 at edge, overrides everything): pc=RESET_PC, npc=RESET_PC+INSTR_BYTES, if_id_flush=0, redirect_pending=0, FSM=RUN, captured target/annul cleared. Applies even mid-stall or with a pending redirect; the captured redirect is discarded.
- Next-value selection (combinational): sel_next = nPC+INSTR_BYTES for 00/10, alu_out for 01, ta for 11. Addition is modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 0.
- Normal update (RUN, le=1): pc<=npc; npc<=sel_next. Latency is 1 cycle from selector to npc. The target becomes pc one cycle later, giving exactly one delay slot.
- if_id_flush: asserted in the cycle after an accepted update whose selector was 01/11 with annul=1; otherwise 0. Never asserted for 00/10, even if annul=1.
- FSM states:
  - RUN: le=1 → update as above, stay RUN. le=0 with selector 01/11 → capture target (alu_out or ta) and annul into hold registers, go PENDING, redirect_pending=1. le=0 with selector 00/10 → go STALL. pc/npc hold in both stall cases.
  - STALL: le=0 with redirect → capture and go PENDING. le=0 without redirect → stay. le=1 → perform a normal update from the current inputs, go RUN.
  - PENDING: pc/npc hold while le=0. New selector values are ignored; the first captured redirect wins. On le=1: pc<=npc, npc<=captured target, if_id_flush pulses next cycle if the captured annul=1, redirect_pending<=0, go RUN. Live selector inputs in that cycle are ignored.
- Simultaneous reset and le=1: reset wins.
- Back-to-back redirects in RUN (jmpl in a delay slot) are legal. Each accepted update uses only that cycle's selector.
- pc and npc are always word aligned when the targets are aligned. No alignment checking is performed in this block.

Test Plan:
1. Reset, then 3 cycles with le=1, selector=00 → pc=0,4,8,C; npc=4,8,C,10; if_id_flush=0 throughout.
2. From pc=8/npc=C: selector=11, ta=32'h100, annul=0, one cycle; then 00 → npc=100 after edge 1; pc=C then 100; npc=104; no flush.
3. Same as test 2 with annul=1 → if_id_flush=1 for exactly the cycle after the redirect is accepted, then 0.
4. Stall capture: le=0, selector=01, alu_out=32'h200, annul=1 for 1 cycle; then 2 stall cycles with selector=11, ta=32'h300; then le=1 → redirect_pending=1 during the stall; pc/npc frozen; on release npc=200 (not 300); flush pulses once; redirect_pending drops to 0.
5. Wrap: force npc=32'hFFFF_FFFC via redirect (ta=FFFF_FFFC), then sequential → npc=0 on the following update.
6. Reset asserted while PENDING → next cycle pc=RESET_PC, npc=RESET_PC+4, redirect_pending=0. The captured target never appears on npc after reset deasserts.
